// File: rtl/symbol_fetch_if.sv
// Command-buffer read port plus committed-attribute outputs of the symbol fetch stage.
interface symbol_fetch_if #(
  parameter int PROG_BITS = 48,
  parameter int NUM_SYM   = 2,
  parameter int RADDR_W   = 2
);
  logic                         prog_re;
  logic [RADDR_W-1:0]           prog_raddr;
  logic [PROG_BITS-1:0]         prog_rdata;
  logic [NUM_SYM-1:0]           valid_idx;
  logic [NUM_SYM*PROG_BITS-1:0] sym_attr;
  logic [NUM_SYM-1:0]           sym_valid;
  logic                         frame_ready;

  modport master (
    output prog_re, prog_raddr, sym_attr, sym_valid, frame_ready,
    input  prog_rdata, valid_idx
  );
  modport slave (
    input  prog_re, prog_raddr, sym_attr, sym_valid, frame_ready,
    output prog_rdata, valid_idx
  );
endinterface

// File: rtl/symbol_fetch.sv
// Frame-synchronous symbol attribute fetch: stage all IDs, then commit atomically.
// Optional macro SYMFETCH_HOLD_INVALID_EN: uninitialized IDs keep their previous commit.

module symbol_fetch_lane #(
  parameter int PROG_BITS = 48
) (
  input  logic                 i_clk,
  input  logic                 rst_pix,
  input  logic                 cap,
  input  logic                 commit,
  input  logic [PROG_BITS-1:0] rdata,
  input  logic                 vld,
  output logic [PROG_BITS-1:0] attr,
  output logic                 valid
);
  logic [PROG_BITS-1:0] stage;
  logic                 stage_v;

  always_ff @(posedge i_clk) begin
    if (rst_pix) begin
      stage   <= '0;
      stage_v <= 1'b0;
      attr    <= '0;
      valid   <= 1'b0;
    end else begin
      if (cap) begin
        stage   <= vld ? rdata : '0;
        stage_v <= vld;
      end
      if (commit) begin
`ifdef SYMFETCH_HOLD_INVALID_EN
        if (stage_v) begin
          attr  <= stage;
          valid <= 1'b1;
        end
`else
        attr  <= stage;
        valid <= stage_v;
`endif
      end
    end
  end
endmodule

module symbol_fetch #(
  parameter int PROG_BITS = 48,
  parameter int NUM_SYM   = 2,
  parameter int RADDR_W   = 2
) (
  input  logic           i_clk,
  input  logic           rst_pix,
  input  logic           n_vsync,
  input  logic           is_sym_mode,
  output logic           busy,
  symbol_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, COMMIT} state_t;

  localparam logic [RADDR_W-1:0] LAST = RADDR_W'(NUM_SYM - 1);

  state_t                             state;
  logic                               vs_q;
  logic [RADDR_W-1:0]                 idx;
  logic                               re_q;
  logic [RADDR_W-1:0]                 raddr_q;
  logic                               fr_q;
  logic [NUM_SYM-1:0]                 cap;
  logic [NUM_SYM-1:0][PROG_BITS-1:0]  attr_q;
  logic [NUM_SYM-1:0]                 vld_q;

  always_ff @(posedge i_clk) begin
    if (rst_pix) begin
      state   <= IDLE;
      vs_q    <= 1'b1;
      idx     <= '0;
      re_q    <= 1'b0;
      raddr_q <= '0;
      busy    <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      vs_q <= n_vsync;
      fr_q <= 1'b0;
      case (state)
        IDLE: if (vs_q && !n_vsync && is_sym_mode) begin
          state   <= READ;
          idx     <= '0;
          re_q    <= 1'b1;
          raddr_q <= '0;
          busy    <= 1'b1;
        end
        READ: begin
          re_q <= 1'b0;
          if (!is_sym_mode) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Losing symbol mode mid-fetch drops the staged frame entirely.
          if (!is_sym_mode) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (idx == LAST) begin
            state <= COMMIT;
          end else begin
            idx     <= idx + RADDR_W'(1);
            raddr_q <= idx + RADDR_W'(1);
            re_q    <= 1'b1;
            state   <= READ;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
          fr_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_lane
    assign cap[i] = (state == WAIT) && is_sym_mode && (idx == RADDR_W'(i));
    symbol_fetch_lane #(.PROG_BITS(PROG_BITS)) u_lane (
      .i_clk  (i_clk),
      .rst_pix(rst_pix),
      .cap    (cap[i]),
      .commit (state == COMMIT),
      .rdata  (bus.prog_rdata),
      .vld    (bus.valid_idx[i]),
      .attr   (attr_q[i]),
      .valid  (vld_q[i])
    );
  end

  assign bus.prog_re     = re_q;
  assign bus.prog_raddr  = raddr_q;
  assign bus.sym_attr    = attr_q;
  assign bus.sym_valid   = vld_q;
  assign bus.frame_ready = fr_q;
endmodule

// File: tb/tb_symbol_fetch.sv
// Scoreboard bench for symbol_fetch: cycle-exact fetch timing, commit contents, abort and reset.
module tb_symbol_fetch;
  localparam int PB = 48;
  localparam int NS = 2;
  localparam int RW = 2;

  logic i_clk = 1'b0;
  logic rst_pix, n_vsync, is_sym_mode, busy;

  symbol_fetch_if #(.PROG_BITS(PB), .NUM_SYM(NS), .RADDR_W(RW)) bus ();

  symbol_fetch #(.PROG_BITS(PB), .NUM_SYM(NS), .RADDR_W(RW)) dut (
    .i_clk      (i_clk),
    .rst_pix    (rst_pix),
    .n_vsync    (n_vsync),
    .is_sym_mode(is_sym_mode),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [PB-1:0] mem [NS];
  always @(posedge i_clk) begin
    if (rst_pix) bus.prog_rdata <= '0;
    else if (bus.prog_re) bus.prog_rdata <= mem[bus.prog_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [NS*PB-1:0] cur_attr;
  logic [NS-1:0]    cur_v;
  logic [NS*PB+NS-1:0] exp_q [$];

  task automatic wait_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Drives the frame-start edge in the current cycle (T); optionally queues the expected commit.
  task automatic start_frame(input logic [NS-1:0] vi, input bit push);
    logic [NS*PB-1:0] ea;
    logic [NS-1:0]    ev;
    for (int i = 0; i < NS; i++) begin
      if (vi[i]) begin
        ea[i*PB +: PB] = mem[i];
        ev[i] = 1'b1;
      end else begin
`ifdef SYMFETCH_HOLD_INVALID_EN
        ea[i*PB +: PB] = cur_attr[i*PB +: PB];
        ev[i] = cur_v[i];
`else
        ea[i*PB +: PB] = '0;
        ev[i] = 1'b0;
`endif
      end
    end
    if (push) exp_q.push_back({ea, ev});
    bus.valid_idx = vi;
    n_vsync = 1'b0;
  endtask

  task automatic check_fetch(input string nm, input bit dbl);
    logic [NS*PB+NS-1:0] e;
    logic [4:0] exp_ctl;
    for (int c = 1; c <= 10; c++) begin
      wait_cycle();
      exp_ctl = {(c == 1 || c == 3), (c >= 3 ? 2'd1 : 2'd0), (c <= 5), (c == 6)};
      n_cmp++;
      if ({bus.prog_re, bus.prog_raddr, busy, bus.frame_ready} !== exp_ctl) begin
        n_err++;
        $display("FAIL %s ctl T+%0d: got re/raddr/busy/fr=%b want %b", nm, c,
                 {bus.prog_re, bus.prog_raddr, busy, bus.frame_ready}, exp_ctl);
      end
      if (c == 6) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          cur_attr = e[NS*PB+NS-1:NS];
          cur_v    = e[NS-1:0];
        end else begin
          n_cmp++; n_err++;
          $display("FAIL %s scoreboard empty at commit", nm);
        end
      end
      n_cmp++;
      if ({bus.sym_attr, bus.sym_valid} !== {cur_attr, cur_v}) begin
        n_err++;
        $display("FAIL %s out T+%0d: got attr=%h v=%b want attr=%h v=%b", nm, c,
                 bus.sym_attr, bus.sym_valid, cur_attr, cur_v);
      end
      if (c == 2) n_vsync = 1'b1;
      if (dbl && c == 2) n_vsync = 1'b0;
      if (dbl && c == 4) n_vsync = 1'b1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard left %0d entries", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_pix = 1'b1; n_vsync = 1'b1; is_sym_mode = 1'b1; bus.valid_idx = '0;
    cur_attr = '0; cur_v = '0;
    repeat (3) wait_cycle();
    n_cmp++;
    if ({bus.prog_re, bus.prog_raddr, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid} !== '0) begin
      n_err++;
      $display("FAIL reset: got re=%b raddr=%0d busy=%b fr=%b attr=%h v=%b want all 0",
               bus.prog_re, bus.prog_raddr, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid);
    end
    rst_pix = 1'b0;
    wait_cycle();
  endtask

  task automatic test_full(input string nm);
    mem[0] = 48'h0000_1111_2222;
    mem[1] = 48'hAAAA_BBBB_CCCC;
    start_frame(2'b11, 1'b1);
    check_fetch(nm, 1'b0);
  endtask

  task automatic test_partial();
    mem[0] = 48'h1234_5678_9ABC;
    mem[1] = 48'hDEAD_BEEF_0001;
    start_frame(2'b01, 1'b1);
    check_fetch("partial_01", 1'b0);
    mem[0] = 48'h5555_6666_7777;
    mem[1] = 48'h0F0F_F0F0_3C3C;
    start_frame(2'b10, 1'b1);
    check_fetch("partial_10", 1'b0);
  endtask

  task automatic test_mode_off();
    is_sym_mode = 1'b0;
    mem[0] = 48'hFFFF_0000_FFFF;
    start_frame(2'b11, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      wait_cycle();
      n_cmp++;
      if ({bus.prog_re, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid} !== {3'b000, cur_attr, cur_v}) begin
        n_err++;
        $display("FAIL mode_off T+%0d: got re=%b busy=%b fr=%b attr=%h want 0/0/0 attr=%h",
                 c, bus.prog_re, busy, bus.frame_ready, bus.sym_attr, cur_attr);
      end
      if (c == 2) n_vsync = 1'b1;
    end
    is_sym_mode = 1'b1;
  endtask

  task automatic test_abort();
    mem[0] = 48'h9999_8888_7777;
    mem[1] = 48'h6666_5555_4444;
    start_frame(2'b11, 1'b0);
    wait_cycle();
    wait_cycle();
    is_sym_mode = 1'b0;
    n_vsync = 1'b1;
    wait_cycle();
    n_cmp++;
    if ({bus.prog_re, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL abort idle T+3: got re=%b busy=%b want 0 0", bus.prog_re, busy);
    end
    is_sym_mode = 1'b1;
    for (int c = 4; c <= 9; c++) begin
      wait_cycle();
      n_cmp++;
      if ({busy, bus.frame_ready, bus.sym_attr, bus.sym_valid} !== {2'b00, cur_attr, cur_v}) begin
        n_err++;
        $display("FAIL abort hold T+%0d: got busy=%b fr=%b attr=%h v=%b want 0 0 attr=%h v=%b",
                 c, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid, cur_attr, cur_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    mem[0] = 48'h0102_0304_0506;
    mem[1] = 48'hA1A2_A3A4_A5A6;
    start_frame(2'b11, 1'b1);
    check_fetch("second_vsync", 1'b1);
  endtask

  task automatic test_reset_mid();
    mem[0] = 48'h1111_1111_1111;
    mem[1] = 48'h2222_2222_2222;
    start_frame(2'b11, 1'b0);
    repeat (4) wait_cycle();
    rst_pix = 1'b1;
    n_vsync = 1'b1;
    wait_cycle();
    cur_attr = '0; cur_v = '0;
    n_cmp++;
    if ({bus.prog_re, bus.prog_raddr, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got re=%b raddr=%0d busy=%b fr=%b attr=%h v=%b want all 0",
               bus.prog_re, bus.prog_raddr, busy, bus.frame_ready, bus.sym_attr, bus.sym_valid);
    end
    rst_pix = 1'b0;
    wait_cycle();
    test_full("after_reset");
  endtask

  initial begin
    test_reset();
    test_full("full_11");
    test_partial();
    test_mode_off();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
